// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of a dual-clock FIFO: read pointer, write-pointer
// synchronizer, and registered empty / half-empty / occupancy / underflow flags.
module fifo_rd_ctrl #(
    parameter int A_Size = 8
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              r_inc,
    input  logic [A_Size:0]   wptr,
    output logic [A_Size:0]   raddr,
    output logic [A_Size:0]   rptr,
    output logic              rempty,
    output logic              hempty,
    output logic [A_Size:0]   rcount,
    output logic              r_underflow
);

    localparam logic [A_Size:0] HALF_DEPTH = {2'b01, {(A_Size-1){1'b0}}};

    logic [A_Size:0] wq1_q, wq1_d;
    logic [A_Size:0] wq2_q, wq2_d;
    logic [A_Size:0] rbin_q, rbin_d;
    logic [A_Size:0] rgray_q, rgray_d;
    logic [A_Size:0] rcount_q, rcount_d;
    logic            rempty_q, rempty_d;
    logic            hempty_q, hempty_d;
    logic            r_underflow_q, r_underflow_d;

    logic [A_Size:0] wq2_bin_s;
    logic [A_Size:0] occ_s;
    logic            pop_s;

    function automatic logic [A_Size:0] gray2bin(input logic [A_Size:0] g);
        logic [A_Size:0] b;
        b[A_Size] = g[A_Size];
        for (int i = A_Size - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Next-state: synchronizer shift, pointer advance and flag computation.
    always_comb begin
        wq1_d         = wptr;
        wq2_d         = wq1_q;
        wq2_bin_s     = gray2bin(wq2_q);
        pop_s         = r_inc & ~rempty_q;
        rbin_d        = rbin_q + {{A_Size{1'b0}}, pop_s};
        rgray_d       = (rbin_d >> 1) ^ rbin_d;
        // Occupancy uses the post-pop pointer so a pop and a new write in the same cycle net out.
        occ_s         = wq2_bin_s - rbin_d;
        rcount_d      = occ_s;
        rempty_d      = (rgray_d == wq2_q);
        hempty_d      = (occ_s < HALF_DEPTH);
        r_underflow_d = r_inc & rempty_q;
    end

    // State register with asynchronous reset to the empty FIFO condition.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            wq1_q         <= {(A_Size+1){1'b0}};
            wq2_q         <= {(A_Size+1){1'b0}};
            rbin_q        <= {(A_Size+1){1'b0}};
            rgray_q       <= {(A_Size+1){1'b0}};
            rcount_q      <= {(A_Size+1){1'b0}};
            rempty_q      <= 1'b1;
            hempty_q      <= 1'b1;
            r_underflow_q <= 1'b0;
        end else begin
            wq1_q         <= wq1_d;
            wq2_q         <= wq2_d;
            rbin_q        <= rbin_d;
            rgray_q       <= rgray_d;
            rcount_q      <= rcount_d;
            rempty_q      <= rempty_d;
            hempty_q      <= hempty_d;
            r_underflow_q <= r_underflow_d;
        end
    end

    assign raddr       = rbin_q;
    assign rptr        = rgray_q;
    assign rcount      = rcount_q;
    assign rempty      = rempty_q;
    assign hempty      = hempty_q;
    assign r_underflow = r_underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed plus randomized bench for fifo_rd_ctrl (A_Size=4) against an
// occupancy-arithmetic reference model.
module tb_fifo_rd_ctrl;

    localparam int AS = 4;

    logic          r_clk = 1'b0;
    logic          r_rst = 1'b1;
    logic          r_inc = 1'b0;
    logic [AS:0]   wptr  = '0;
    logic [AS:0]   raddr, rptr, rcount;
    logic          rempty, hempty, r_underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: integer pointers (mod 32) and a two-deep sync delay.
    int wcount, m_rd, m_wq1, m_wq2, m_count;
    bit m_empty, m_hempty, m_under, wrapped;
    logic [AS:0] prev_rptr, prev_raddr;

    fifo_rd_ctrl #(.A_Size(AS)) dut (
        .r_clk(r_clk), .r_rst(r_rst), .r_inc(r_inc), .wptr(wptr),
        .raddr(raddr), .rptr(rptr), .rempty(rempty), .hempty(hempty),
        .rcount(rcount), .r_underflow(r_underflow)
    );

    always #5 r_clk = ~r_clk;

    function automatic logic [AS:0] to_gray(input int b);
        logic [AS:0] v;
        v = b[AS:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_writes(input int n);
        wcount = (wcount + n) & 31;
        wptr   = to_gray(wcount);
    endtask

    task automatic model_reset();
        wcount = 0; m_rd = 0; m_wq1 = 0; m_wq2 = 0; m_count = 0;
        m_empty = 1'b1; m_hempty = 1'b1; m_under = 1'b0;
        prev_rptr = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rempty"}, 32'(rempty), 32'd1);
        chk({tag, "_hempty"}, 32'(hempty), 32'd1);
        chk({tag, "_rcount"}, 32'(rcount), 32'd0);
        chk({tag, "_raddr"},  32'(raddr),  32'd0);
        chk({tag, "_rptr"},   32'(rptr),   32'd0);
        chk({tag, "_under"},  32'(r_underflow), 32'd0);
    endtask

    // One clock edge with r_inc = inc; model advances, then all outputs compared.
    task automatic step(input bit inc);
        bit pop;
        int occ;
        r_inc = inc;
        prev_rptr  = rptr;
        prev_raddr = raddr;
        @(posedge r_clk);
        pop     = inc && !m_empty;
        m_under = inc && m_empty;
        m_rd    = (m_rd + (pop ? 1 : 0)) & 31;
        occ     = (m_wq2 - m_rd) & 31;
        m_count = occ;
        m_empty = (occ == 0);
        m_hempty = (occ < 8);
        m_wq2   = m_wq1;
        m_wq1   = wcount;
        #1;
        chk("raddr",  32'(raddr),  32'(m_rd));
        chk("rptr",   32'(rptr),   32'(to_gray(m_rd)));
        chk("rcount", 32'(rcount), 32'(m_count));
        chk("rempty", 32'(rempty), 32'(m_empty));
        chk("hempty", 32'(hempty), 32'(m_hempty));
        chk("underflow", 32'(r_underflow), 32'(m_under));
        chk("rptr_bits", 32'($countones(rptr ^ prev_rptr)), pop ? 32'd1 : 32'd0);
        if (pop && prev_raddr == 5'd31 && raddr == 5'd0) wrapped = 1'b1;
        r_inc = 1'b0;
    endtask

    task automatic do_reset();
        r_rst = 1'b1;
        r_inc = 1'b0;
        model_reset();
        wptr = '0;
        repeat (2) @(posedge r_clk);
        #1;
        chk_reset_vals("rst");
        r_rst = 1'b0;
    endtask

    initial begin
        int writes;
        wrapped = 1'b0;
        model_reset();

        // Reset state and underflow pulse
        do_reset();
        step(1'b1);
        chk("under_pulse", 32'(r_underflow), 32'd1);
        chk("under_raddr", 32'(raddr), 32'd0);
        step(1'b0);
        chk("under_clear", 32'(r_underflow), 32'd0);

        // Three entries become visible two edges after capture
        set_writes(3);
        step(1'b0);
        step(1'b0);
        chk("vis_not_yet", 32'(rempty), 32'd1);
        step(1'b0);
        chk("vis_count3", 32'(rcount), 32'd3);
        chk("vis_nonempty", 32'(rempty), 32'd0);
        step(1'b1); chk("pop1_raddr", 32'(raddr), 32'd1);
        step(1'b1); chk("pop2_raddr", 32'(raddr), 32'd2);
        step(1'b1); chk("pop3_raddr", 32'(raddr), 32'd3);
        chk("pop3_empty", 32'(rempty), 32'd1);

        // Full FIFO then pop down through the half mark
        set_writes(16);
        repeat (3) step(1'b0);
        chk("full_count", 32'(rcount), 32'd16);
        chk("full_hempty", 32'(hempty), 32'd0);
        repeat (8) step(1'b1);
        chk("pop8_hempty", 32'(hempty), 32'd0);
        step(1'b1);
        chk("pop9_count", 32'(rcount), 32'd7);
        chk("pop9_hempty", 32'(hempty), 32'd1);

        // Randomized writes and pops across the pointer wrap
        writes = 0;
        for (int c = 0; c < 200; c++) begin
            if (writes < 40 && ((wcount - m_rd) & 31) < 16 && $urandom_range(0, 1) == 1) begin
                set_writes(1);
                writes++;
            end
            step($urandom_range(0, 2) != 0);
        end
        for (int c = 0; c < 40; c++) step(1'b1);
        chk("drained_raddr", 32'(raddr), 32'(wcount));
        chk("drained_empty", 32'(rempty), 32'd1);
        chk("wrap_seen", 32'(wrapped), 32'd1);

        // Pop on the edge where a new write becomes visible: count holds
        set_writes(5);
        repeat (3) step(1'b0);
        chk("sim_count5", 32'(rcount), 32'd5);
        set_writes(1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        chk("sim_count", 32'(rcount), 32'd5);
        chk("sim_empty", 32'(rempty), 32'd0);

        // Asynchronous reset mid-burst
        do_reset();
        set_writes(12);
        repeat (3) step(1'b0);
        repeat (9) step(1'b1);
        chk("burst_raddr", 32'(raddr), 32'd9);
        r_inc = 1'b1;
        #2;
        r_rst = 1'b1;
        #1;
        chk_reset_vals("async");
        r_inc = 1'b0;
        model_reset();
        wptr = '0;
        @(posedge r_clk);
        #1;
        r_rst = 1'b0;
        step(1'b0);
        step(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
